// File: rtl/acq_sequencer.sv
// Triggered acquisition sequencer: a PC command byte arms a threshold trigger, then
// fixed-length records of ADC samples are written to a downstream FIFO.
module acq_sequencer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_data,
  output logic [1:0] state,
  output logic       disableout,
  output logic       overflow,
  output logic [7:0] rec_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10
  } state_e;

  localparam logic [2:0] OP_SET_THR  = 3'b001;
  localparam logic [2:0] OP_STOP     = 3'b010;
  localparam logic [2:0] OP_SET_LEN  = 3'b011;
  localparam logic [2:0] OP_ARM_SGL  = 3'b100;
  localparam logic [2:0] OP_ARM_CONT = 3'b110;

  state_e      state_q, state_d;
  logic [7:0]  threshold_q, threshold_d;
  logic [7:0]  record_len_q, record_len_d;
  logic [8:0]  count_q, count_d;
  logic        cont_q, cont_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  rec_count_q, rec_count_d;
  logic        fifo_wr_q, fifo_wr_d;
  logic [7:0]  fifo_data_q, fifo_data_d;

  logic [2:0]  opcode;
  logic [4:0]  arg;
  logic        cmd_thr, cmd_stop, cmd_len, cmd_arm_s, cmd_arm_c, cmd_arm;
  logic        in_idle;
  logic        rec_sample, accept, drop, rec_done;
  logic [8:0]  count_inc;

  // Command decode and record-sample qualification
  always_comb begin
    opcode    = cmd_data[2:0];
    arg       = cmd_data[7:3];
    cmd_thr   = cmd_valid && (opcode == OP_SET_THR);
    cmd_stop  = cmd_valid && (opcode == OP_STOP);
    cmd_len   = cmd_valid && (opcode == OP_SET_LEN);
    cmd_arm_s = cmd_valid && (opcode == OP_ARM_SGL);
    cmd_arm_c = cmd_valid && (opcode == OP_ARM_CONT);
    cmd_arm   = cmd_arm_s || cmd_arm_c;
    in_idle   = (state_q == S_IDLE);

    // The trigger sample itself is the first sample of the record.
    rec_sample = adc_valid &&
                 ((state_q == S_CAPTURE) ||
                  ((state_q == S_ARMED) && (adc_data >= threshold_q)));
    accept     = rec_sample && !fifo_full;
    drop       = rec_sample && fifo_full;
    count_inc  = count_q + 9'd1;
    rec_done   = accept && (count_inc == ({1'b0, record_len_q} + 9'd1));
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state, priority STOP > record completion > trigger/arm
  always_comb begin
    state_d = state_q;
    if (cmd_stop) begin
      state_d = S_IDLE;
    end else if (rec_done) begin
      state_d = cont_q ? S_ARMED : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (cmd_arm) state_d = S_ARMED;
        S_ARMED:   if (rec_sample) state_d = S_CAPTURE;
        S_CAPTURE: state_d = S_CAPTURE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    state      = state_q;
    disableout = (state_q != S_CAPTURE);
  end

  // Datapath and configuration next-state
  always_comb begin
    threshold_d  = threshold_q;
    record_len_d = record_len_q;
    count_d      = count_q;
    cont_d       = cont_q;
    overflow_d   = overflow_q;
    rec_count_d  = rec_count_q;
    fifo_wr_d    = accept;
    fifo_data_d  = accept ? adc_data : fifo_data_q;

    // Same-cycle compare above still sees the old threshold.
    if (cmd_thr) threshold_d = {arg, 3'b000};
    if (cmd_len && in_idle) record_len_d = {arg, 3'b111};

    if (cmd_arm && in_idle) begin
      cont_d     = cmd_arm_c;
      overflow_d = 1'b0;
    end
    if (drop) overflow_d = 1'b1;

    if (rec_done) rec_count_d = rec_count_q + 8'd1;

    if (cmd_stop || rec_done) begin
      count_d = 9'd0;
    end else if (accept) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      threshold_q  <= 8'h80;
      record_len_q <= 8'h0F;
      count_q      <= 9'd0;
      cont_q       <= 1'b0;
      overflow_q   <= 1'b0;
      rec_count_q  <= 8'd0;
      fifo_wr_q    <= 1'b0;
      fifo_data_q  <= 8'd0;
    end else begin
      threshold_q  <= threshold_d;
      record_len_q <= record_len_d;
      count_q      <= count_d;
      cont_q       <= cont_d;
      overflow_q   <= overflow_d;
      rec_count_q  <= rec_count_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign fifo_wr   = fifo_wr_q;
  assign fifo_data = fifo_data_q;
  assign overflow  = overflow_q;
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: one task per scenario, expected values hand-derived.
module tb_acq_sequencer;

  logic       clock;
  logic       reset_n;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       fifo_full;
  logic       fifo_wr;
  logic [7:0] fifo_data;
  logic [1:0] state;
  logic       disableout;
  logic       overflow;
  logic [7:0] rec_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_seen = 0;

  acq_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .state      (state),
    .disableout (disableout),
    .overflow   (overflow),
    .rec_count  (rec_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs, sample 1 time unit after the edge, count writes.
  task automatic step(input logic cv, input logic [7:0] cd, input logic av,
                      input logic [7:0] ad, input logic ff);
    cmd_valid = cv;
    cmd_data  = cd;
    adc_valid = av;
    adc_data  = ad;
    fifo_full = ff;
    @(posedge clock);
    #1;
    if (fifo_wr === 1'b1) wr_seen++;
    cmd_valid = 1'b0;
    adc_valid = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    wr_seen = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_data = 8'h00;
    adc_valid = 1'b0; adc_data = 8'h00; fifo_full = 1'b0;
    #3;
    total_cnt++; if (state !== 2'b00) $display("FAIL rst_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL rst_fifo_wr got %0b want 0", fifo_wr); else pass_cnt++;
    total_cnt++; if (fifo_data !== 8'h00) $display("FAIL rst_fifo_data got %0h want 0", fifo_data); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %0b want 0", overflow); else pass_cnt++;
    total_cnt++; if (rec_count !== 8'h00) $display("FAIL rst_rec_count got %0h want 0", rec_count); else pass_cnt++;
    total_cnt++; if (disableout !== 1'b1) $display("FAIL rst_disableout got %0b want 1", disableout); else pass_cnt++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1'b1, 8'h07, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'h05, 1'b1, 8'hFF, 1'b0);
    total_cnt++; if (state !== 2'b00) $display("FAIL ignored_op_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (wr_seen !== 0) $display("FAIL idle_writes got %0d want 0", wr_seen); else pass_cnt++;
  endtask

  task automatic test_trigger_and_record();
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (state !== 2'b01) $display("FAIL arm_state got %0h want 1", state); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h10, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL below_thr_10 got %0b want 0", fifo_wr); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h7F, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL below_thr_7f got %0b want 0", fifo_wr); else pass_cnt++;
    total_cnt++; if (state !== 2'b01) $display("FAIL still_armed got %0h want 1", state); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h80, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b1) $display("FAIL trig_wr got %0b want 1", fifo_wr); else pass_cnt++;
    total_cnt++; if (fifo_data !== 8'h80) $display("FAIL trig_data got %0h want 80", fifo_data); else pass_cnt++;
    total_cnt++; if (state !== 2'b10) $display("FAIL trig_state got %0h want 2", state); else pass_cnt++;
    total_cnt++; if (disableout !== 1'b0) $display("FAIL trig_disableout got %0b want 0", disableout); else pass_cnt++;
    for (int i = 1; i <= 14; i++) step(1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
    total_cnt++; if (state !== 2'b10) $display("FAIL rec15_state got %0h want 2", state); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
    total_cnt++; if (fifo_data !== 8'h3C) $display("FAIL rec16_data got %0h want 3c", fifo_data); else pass_cnt++;
    total_cnt++; if (state !== 2'b00) $display("FAIL rec16_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (rec_count !== 8'd1) $display("FAIL rec16_count got %0d want 1", rec_count); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL post_rec_wr got %0b want 0", fifo_wr); else pass_cnt++;
    total_cnt++; if (wr_seen !== 16) $display("FAIL rec_writes got %0d want 16", wr_seen); else pass_cnt++;
  endtask

  task automatic test_continuous();
    do_reset();
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h06, 1'b0, 8'h00, 1'b0);
    for (int b = 0; b < 2; b++) begin
      step(1'b0, 8'h00, 1'b1, 8'h05, 1'b0);
      step(1'b0, 8'h00, 1'b1, 8'h90, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 8'h20 + 8'(i), 1'b0);
      total_cnt++; if (state !== 2'b01) $display("FAIL cont_burst%0d_state got %0h want 1", b, state); else pass_cnt++;
    end
    total_cnt++; if (wr_seen !== 16) $display("FAIL cont_writes got %0d want 16", wr_seen); else pass_cnt++;
    total_cnt++; if (rec_count !== 8'd2) $display("FAIL cont_rec_count got %0d want 2", rec_count); else pass_cnt++;
  endtask

  task automatic test_len_ignored_when_armed();
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
    total_cnt++; if (state !== 2'b10) $display("FAIL len_ignored_state got %0h want 2", state); else pass_cnt++;
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
    total_cnt++; if (state !== 2'b00) $display("FAIL len_default_done got %0h want 0", state); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hA0, 1'b1);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL ovf_trig_wr got %0b want 0", fifo_wr); else pass_cnt++;
    total_cnt++; if (state !== 2'b10) $display("FAIL ovf_trig_state got %0h want 2", state); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", overflow); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'hA1, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hA2, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
    total_cnt++; if (state !== 2'b10) $display("FAIL ovf_15_state got %0h want 2", state); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    total_cnt++; if (wr_seen !== 16) $display("FAIL ovf_writes got %0d want 16", wr_seen); else pass_cnt++;
    total_cnt++; if (state !== 2'b00) $display("FAIL ovf_done_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (rec_count !== 8'd1) $display("FAIL ovf_rec_count got %0d want 1", rec_count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", overflow); else pass_cnt++;
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_cleared got %0b want 0", overflow); else pass_cnt++;
  endtask

  task automatic test_stop_and_threshold();
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h02, 1'b1, 8'h44, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b1) $display("FAIL stop_wr got %0b want 1", fifo_wr); else pass_cnt++;
    total_cnt++; if (fifo_data !== 8'h44) $display("FAIL stop_data got %0h want 44", fifo_data); else pass_cnt++;
    total_cnt++; if (state !== 2'b00) $display("FAIL stop_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (rec_count !== 8'd0) $display("FAIL stop_rec_count got %0d want 0", rec_count); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL stop_after_wr got %0b want 0", fifo_wr); else pass_cnt++;
    step(1'b1, 8'hF9, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hF7, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL thr_f7_wr got %0b want 0", fifo_wr); else pass_cnt++;
    step(1'b0, 8'h00, 1'b1, 8'hF8, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b1) $display("FAIL thr_f8_wr got %0b want 1", fifo_wr); else pass_cnt++;
    total_cnt++; if (state !== 2'b10) $display("FAIL thr_f8_state got %0h want 2", state); else pass_cnt++;
    // SET_THR together with a sample: the compare uses the threshold in force this cycle.
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hF9, 1'b1, 8'h90, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b1) $display("FAIL thr_old_value_wr got %0b want 1", fifo_wr); else pass_cnt++;
    step(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h90, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL thr_new_value_wr got %0b want 0", fifo_wr); else pass_cnt++;
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
    adc_valid = 1'b1;
    adc_data  = 8'h02;
    reset_n   = 1'b0;
    #1;
    total_cnt++; if (state !== 2'b00) $display("FAIL midrst_state got %0h want 0", state); else pass_cnt++;
    total_cnt++; if (fifo_wr !== 1'b0) $display("FAIL midrst_wr got %0b want 0", fifo_wr); else pass_cnt++;
    total_cnt++; if (fifo_data !== 8'h00) $display("FAIL midrst_data got %0h want 0", fifo_data); else pass_cnt++;
    total_cnt++; if (disableout !== 1'b1) $display("FAIL midrst_disableout got %0b want 1", disableout); else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    adc_valid = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    total_cnt++; if (wr_seen !== 0) $display("FAIL midrst_no_writes got %0d want 0", wr_seen); else pass_cnt++;
    total_cnt++; if (state !== 2'b00) $display("FAIL midrst_idle got %0h want 0", state); else pass_cnt++;
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hC0, 1'b0);
    total_cnt++; if (fifo_wr !== 1'b1) $display("FAIL midrst_rearm_wr got %0b want 1", fifo_wr); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_trigger_and_record();
    test_continuous();
    test_len_ignored_when_armed();
    test_overflow();
    test_stop_and_threshold();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
